// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences operand triples through a pipelined MAC and returns the 64-bit sum of all results.
module mac_dot_seq #(
  parameter int LATENCY = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start_valid,
  input  logic [15:0] start_len,
  output logic        start_ready,
  input  logic        op_valid,
  input  logic [31:0] op_m1,
  input  logic [31:0] op_m2,
  input  logic [31:0] op_addend,
  output logic        op_ready,
  output logic [31:0] get_values_multiplicand1,
  output logic [31:0] get_values_multiplicand2,
  output logic [31:0] get_values_addend,
  output logic        EN_get_values,
  input  logic        RDY_get_values,
  input  logic [63:0] mac_result,
  input  logic        RDY_mac_result,
  output logic        EN_mac_result,
  output logic [63:0] sum,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic        busy
);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, DONE} state_t;
  state_t        state_q, state_d;
  logic [63:0]   acc_q, acc_d, cached_q, cached_d;
  logic [95:0]   cur_q, cur_d, last_q, last_d;
  logic [15:0]   rem_q, rem_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [95:0]   op_in;
  assign op_in = {op_m1, op_m2, op_addend};
  assign {get_values_multiplicand1, get_values_multiplicand2, get_values_addend} = cur_q;
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    cached_d      = cached_q;
    cur_d         = cur_q;
    last_d        = last_q;
    rem_d         = rem_q;
    wcnt_d        = wcnt_q;
    start_ready   = state_q == IDLE;
    op_ready      = state_q == FETCH;
    EN_get_values = state_q == ISSUE && RDY_get_values;
    // RDY_mac_result alone may reflect the previous issue, so the countdown gates it
    EN_mac_result = state_q == WAIT && wcnt_q <= CW'(1) && RDY_mac_result;
    sum_valid     = state_q == DONE;
    sum           = sum_valid ? acc_q : '0;
    busy          = state_q != IDLE;
    case (state_q)
      IDLE: if (start_valid) begin
        rem_d   = start_len;
        acc_d   = '0;
        state_d = start_len == '0 ? DONE : FETCH;
      end
      FETCH: if (op_valid) begin
        cur_d = op_in;
        if (op_in == last_q) begin
          acc_d   = acc_q + cached_q;
          rem_d   = rem_q - 16'd1;
          state_d = rem_q == 16'd1 ? DONE : FETCH;
        end else
          state_d = ISSUE;
      end
      ISSUE: if (EN_get_values) begin
        last_d  = cur_q;
        wcnt_d  = CW'(LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q == '0 ? '0 : wcnt_q - CW'(1);
        if (EN_mac_result) begin
          acc_d    = acc_q + mac_result;
          cached_d = mac_result;
          rem_d    = rem_q - 16'd1;
          state_d  = rem_q == 16'd1 ? DONE : FETCH;
        end
      end
      DONE: state_d = sum_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cached_q <= '0;
      cur_q    <= '0;
      last_q   <= '0;
      rem_q    <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cached_q <= cached_d;
      cur_q    <= cur_d;
      last_q   <= last_d;
      rem_q    <= rem_d;
      wcnt_q   <= wcnt_d;
    end
  end
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: directed jobs against a behavioural MAC, sums checked through a scoreboard.
module tb_mac_dot_seq;
  localparam int LAT = 3;
  logic        CLK = 1'b0, RST = 1'b1;
  logic        start_valid = 1'b0, op_valid = 1'b0, sum_ready = 1'b0;
  logic [15:0] start_len = '0;
  logic [31:0] op_m1 = '0, op_m2 = '0, op_addend = '0;
  logic        start_ready, op_ready, EN_get_values, EN_mac_result, sum_valid, busy;
  logic [31:0] gv_m1, gv_m2, gv_add;
  logic [63:0] sum;
  logic        RDY_get_values = 1'b1, RDY_mac_result = 1'b1;
  logic [63:0] mres = '0, pend = '0;
  logic [95:0] mac_last = '0;
  int          d = 0, cyc = 0;

  mac_dot_seq #(.LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST),
    .start_valid(start_valid), .start_len(start_len), .start_ready(start_ready),
    .op_valid(op_valid), .op_m1(op_m1), .op_m2(op_m2), .op_addend(op_addend), .op_ready(op_ready),
    .get_values_multiplicand1(gv_m1), .get_values_multiplicand2(gv_m2), .get_values_addend(gv_add),
    .EN_get_values(EN_get_values), .RDY_get_values(RDY_get_values),
    .mac_result(mres), .RDY_mac_result(RDY_mac_result), .EN_mac_result(EN_mac_result),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [63:0] prod(input logic [95:0] t);
    return 64'(t[95:64]) * 64'(t[63:32]) + 64'(t[31:0]);
  endfunction

  function automatic logic [95:0] tr3(input logic [31:0] a, b, c);
    return {a, b, c};
  endfunction

  // behavioural MAC: result appears LAT cycles after the issue, stale value held until then
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RST) begin
      mres <= '0; d <= 0; mac_last <= '0;
    end else if (EN_get_values) begin
      pend <= prod({gv_m1, gv_m2, gv_add}); d <= LAT - 1; mac_last <= {gv_m1, gv_m2, gv_add};
    end else if (d > 0) begin
      d <= d - 1;
      if (d == 1) mres <= pend;
    end
  end

  int n_issue = 0, n_cons = 0, issue_cyc = 0, cons_cyc = 0, bad_evt = 0;
  always @(negedge CLK) if (!RST) begin
    if (EN_get_values) begin
      n_issue++; issue_cyc = cyc;
      if ({gv_m1, gv_m2, gv_add} === mac_last) bad_evt++;
    end
    if (EN_mac_result) begin
      n_cons++; cons_cyc = cyc;
      if (d != 0) bad_evt++;
    end
  end

  int          vec = 0, bad = 0, sv_wait = 0, last_acc_cyc = 0, prev_acc_cyc = 0;
  logic [63:0] sb_sum[$];
  int          sb_iss[$];
  logic [95:0] model_last = '0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, {start_ready, busy, op_ready, EN_get_values, EN_mac_result, sum_valid}, 6'b100000);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_gv"}, {gv_m1, gv_m2, gv_add}, 0);
  endtask

  task automatic do_reset();
    op_valid = 0; start_valid = 0; sum_ready = 0;
    RST = 1; @(negedge CLK);
    chk_idle("reset");
    RST = 0; model_last = '0;
    sb_sum.delete(); sb_iss.delete();
  endtask

  task automatic start_job(input int n);
    int k = 0;
    while (!start_ready && k < 100) begin @(negedge CLK); k++; end
    chk("start_ready", start_ready, 1);
    start_valid = 1; start_len = 16'(n);
    @(negedge CLK);
    start_valid = 0;
  endtask

  task automatic send_op(input logic [95:0] t);
    int k = 0;
    op_valid = 1; {op_m1, op_m2, op_addend} = t;
    while (!op_ready && k < 100) begin @(negedge CLK); k++; end
    chk("op_accept", op_ready, 1);
    prev_acc_cyc = last_acc_cyc; last_acc_cyc = cyc;
    @(negedge CLK);
  endtask

  task automatic get_sum(input int hold);
    int k = 0;
    logic [63:0] s;
    while (!sum_valid && k < 200) begin @(negedge CLK); k++; end
    sv_wait = k;
    chk("sum_valid", sum_valid, 1);
    s = sum;
    repeat (hold) begin
      @(negedge CLK);
      chk("hold_valid", sum_valid, 1);
      chk("hold_sum", sum, s);
    end
    chk("sum", sum, sb_sum.pop_front());
    sum_ready = 1; @(negedge CLK); sum_ready = 0;
    chk("back_idle", {start_ready, busy, sum_valid}, 3'b100);
  endtask

  task automatic run_job(input int n, input logic [95:0] tr[4], input int hold);
    logic [63:0] es = '0;
    int ei = 0, i0 = n_issue, c0 = n_cons, e0 = bad_evt;
    for (int i = 0; i < n; i++) begin
      es += prod(tr[i]);
      if (tr[i] !== model_last) begin ei++; model_last = tr[i]; end
    end
    sb_sum.push_back(es); sb_iss.push_back(ei);
    start_job(n);
    for (int i = 0; i < n; i++) send_op(tr[i]);
    op_valid = 0;
    get_sum(hold);
    chk("issues", n_issue - i0, sb_iss.pop_front());
    chk("consumes", n_cons - c0, ei);
    chk("mac_protocol", bad_evt - e0, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    repeat (2) @(negedge CLK);
    do_reset();
    run_job(1, '{tr3(3, 4, 5), 96'd0, 96'd0, 96'd0}, 2);
    chk("issue_lat", issue_cyc - last_acc_cyc, 1);
    chk("consume_lat", cons_cyc - issue_cyc, LAT);
    run_job(3, '{tr3(32'hFFFFFFFF, 32'hFFFFFFFF, 1), tr3(2, 3, 0), tr3(1, 1, 1), 96'd0}, 0);
    run_job(3, '{tr3(7, 8, 9), tr3(7, 8, 9), tr3(7, 8, 9), 96'd0}, 0);
    chk("dup_back_to_back", last_acc_cyc - prev_acc_cyc, 1);
    chk("dup_done_latency", sv_wait, 0);
    do_reset();
    run_job(2, '{tr3(0, 0, 0), tr3(1, 2, 3), 96'd0, 96'd0}, 0);
    run_job(0, '{96'd0, 96'd0, 96'd0, 96'd0}, 4);
    chk("zero_len_latency", sv_wait, 0);
    start_job(4);
    send_op(tr3(1, 2, 3));
    send_op(tr3(4, 5, 6));
    @(negedge CLK);
    chk("mid_job_busy", busy, 1);
    do_reset();
    run_job(1, '{tr3(0, 0, 0), 96'd0, 96'd0, 96'd0}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
